uart_bus_master: RTL and testbench
==================================

// Module: uart_bus_master
// PURPOSE
//  Host-side debug/loader bridge: decodes a byte command stream from rx_uart and acts as
//  a second initiator on the SoC valid/ready memory bus (word read/write to BRAM, SDRAM, IO).
//  Responses go back as bytes to tx_uart. Sits beside the CPU behind a req/gnt arbiter;
//  lets the host load firmware into SDRAM and peek/poke registers with the CPU stalled.
// PARAMETERS
//  BYTE_TIMEOUT  32'd1_000_000  idle clks between command bytes before a partial command is dropped
//  BUS_TIMEOUT   16'd4095       clks mem_valid may stay high without mem_ready before abort
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  rx_data    in   8   received byte
//  rx_valid   in   1   1-clk strobe, rx_data valid
//  tx_data    out  8   byte to transmit
//  tx_valid   out  1   tx_data valid; held until tx_ready
//  tx_ready   in   1   transmitter accepts byte when tx_valid&&tx_ready
//  bus_req    out  1   request bus ownership from arbiter
//  bus_gnt    in   1   ownership granted (CPU stalled)
//  mem_valid  out  1   bus request valid
//  mem_ready  in   1   responder done; rdata valid this clk
//  mem_addr   out  32  byte address, [1:0] always 2'b00
//  mem_wdata  out  32  write data
//  mem_wstrb  out  4   4'hF write, 4'h0 read
//  mem_rdata  in   32  read data
//  busy       out  1   command in progress (state != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. rst mid-command aborts without response.
//  Commands (multi-byte fields little-endian):
//   'P' 0x50                 -> reply 0x06
//   'R' 0x52 A0..A3          -> bus read, reply D0..D3 (rdata LE)
//   'W' 0x57 A0..A3 D0..D3   -> bus write wstrb=F, reply 0x06
//   other byte in IDLE       -> reply 0x15, stay IDLE
//  FSM: IDLE -> ADDR(4 bytes) -> [W] DATA(4 bytes) -> REQ -> BUS -> RESP -> IDLE; 'P' IDLE->RESP.
//  2-bit byte index wraps 3->0 on field completion. addr bits [1:0] received but forced 0 on bus.
//  Byte timer resets on each rx_valid; reaching BYTE_TIMEOUT in ADDR/DATA -> IDLE, no reply.
//  rx_valid outside IDLE/ADDR/DATA (REQ, BUS, RESP) is ignored (byte dropped).
//  REQ: bus_req=1; on first clk with bus_gnt=1 -> BUS, mem_valid=1 next edge.
//  bus_req stays 1 from REQ entry until BUS exit.
//  BUS: mem_addr/wdata/wstrb stable while mem_valid; clk with mem_ready=1: capture rdata,
//   mem_valid=0 and bus_req=0 at next edge (mem_ready with mem_valid=0 ignored).
//  Bus timer counts BUS clks; reaching BUS_TIMEOUT -> drop mem_valid/bus_req, reply 0x15.
//  bus_gnt falling during BUS: mem_valid stays until mem_ready or timeout (arbiter must not revoke).
//  RESP: tx_valid=1 with byte k; advance on tx_valid&&tx_ready; last byte accepted -> IDLE.
//   rx_valid during RESP ignored. tx_data stable while tx_valid && !tx_ready.
//  Latency: last command byte -> bus_req next clk; mem_ready -> tx_valid within 2 clks.
// STRUCTURE
//  Shared package/header (defines_soc.vh): CMD_PING/CMD_READ/CMD_WRITE, ACK 8'h06, NAK 8'h15,
//   state encoding localparams.
//  Single module; no sub-module (shift registers, two timers and FSM fit comfortably).
// TESTING
//  'P' -> tx 0x06 exactly once, bus_req never asserted.
//  'W' 00 00 00 40 EF BE AD DE, gnt after 3 clks, ready after 5 -> one write
//   addr 0x4000_0000 wdata 0xDEADBEEF wstrb F; reply 0x06.
//  'R' 2B 00 10 20, rdata 0x1234_5678 -> addr 0x2010_0028 wstrb 0; tx 78 56 34 12,
//   tx_ready toggled randomly, bytes unchanged under backpressure.
//  'R' + 2 addr bytes then silence BYTE_TIMEOUT -> back to IDLE, no tx; next 'P' -> 0x06.
//  'R' to address never giving mem_ready -> mem_valid drops after BUS_TIMEOUT, reply 0x15.
//  rst asserted during BUS -> all outputs 0 immediately; 0x41 in IDLE -> 0x15.

Source files
------------

// File: rtl/uart_bus_master_pkg.sv
// Shared command codes, reply bytes and FSM state type for the UART debug bus master.
package uart_bus_master_pkg;

    localparam logic [7:0] CMD_PING  = 8'h50;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_BUS,
        ST_RESP
    } state_t;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// Byte-stream (rx/tx), arbiter and valid/ready memory bus signals of the UART bus master.
interface uart_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_gnt, mem_ready, mem_rdata,
        output tx_data, tx_valid, bus_req, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_gnt, mem_ready, mem_rdata,
        input  tx_data, tx_valid, bus_req, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy
    );
endinterface

// File: rtl/uart_bus_master.sv
// Host debug/loader bridge: decodes P/R/W byte commands and issues single-word bus
// transactions as a second initiator behind the req/gnt arbiter, replying over tx.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter logic [31:0] BYTE_TIMEOUT = 32'd1_000_000,
    parameter logic [15:0] BUS_TIMEOUT  = 16'd4095
) (
    input  logic                clk,
    input  logic                rst,
    uart_bus_master_if.master   io
);

    state_t      state_q, state_d;
    logic        is_write_q;
    logic [1:0]  idx_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_q;
    logic [1:0]  resp_last_q;
    logic [1:0]  resp_idx_q;
    logic [31:0] byte_tmr_q;
    logic [15:0] bus_tmr_q;

    logic byte_to;
    logic bus_to;
    logic in_field;

    assign in_field = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign byte_to  = (byte_tmr_q == BYTE_TIMEOUT - 32'd1);
    assign bus_to   = (bus_tmr_q == BUS_TIMEOUT - 16'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (io.rx_valid) begin
                    if (io.rx_data == CMD_READ || io.rx_data == CMD_WRITE)
                        state_d = ST_ADDR;
                    else
                        state_d = ST_RESP;
                end
            end
            ST_ADDR: begin
                if (io.rx_valid) begin
                    if (idx_q == 2'd3)
                        state_d = is_write_q ? ST_DATA : ST_REQ;
                end else if (byte_to) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (io.rx_valid) begin
                    if (idx_q == 2'd3)
                        state_d = ST_REQ;
                end else if (byte_to) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (io.bus_gnt)
                    state_d = ST_BUS;
            end
            ST_BUS: begin
                if (io.mem_ready || bus_to)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                if (io.tx_ready && resp_idx_q == resp_last_q)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            idx_q       <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_q      <= '0;
            resp_last_q <= 2'd0;
            resp_idx_q  <= 2'd0;
            byte_tmr_q  <= '0;
            bus_tmr_q   <= '0;
        end else begin
            state_q <= state_d;

            // Inter-byte silence is only timed while a command field is partially received.
            if (io.rx_valid || !in_field)
                byte_tmr_q <= '0;
            else
                byte_tmr_q <= byte_tmr_q + 32'd1;

            case (state_q)
                ST_IDLE: begin
                    idx_q      <= 2'd0;
                    resp_idx_q <= 2'd0;
                    if (io.rx_valid) begin
                        is_write_q  <= (io.rx_data == CMD_WRITE);
                        resp_last_q <= 2'd0;
                        if (io.rx_data == CMD_PING)
                            resp_q <= {24'h0, ACK};
                        else
                            resp_q <= {24'h0, NAK};
                    end
                end
                ST_ADDR: begin
                    // Little-endian: each byte enters at the top and the word shifts down.
                    if (io.rx_valid) begin
                        addr_q <= {io.rx_data, addr_q[31:10]};
                        idx_q  <= idx_q + 2'd1;
                    end
                end
                ST_DATA: begin
                    if (io.rx_valid) begin
                        wdata_q <= {io.rx_data, wdata_q[31:8]};
                        idx_q   <= idx_q + 2'd1;
                    end
                end
                ST_REQ: begin
                    bus_tmr_q <= '0;
                end
                ST_BUS: begin
                    bus_tmr_q <= bus_tmr_q + 16'd1;
                    if (io.mem_ready) begin
                        resp_q      <= is_write_q ? {24'h0, ACK} : io.mem_rdata;
                        resp_last_q <= is_write_q ? 2'd0 : 2'd3;
                    end else if (bus_to) begin
                        resp_q      <= {24'h0, NAK};
                        resp_last_q <= 2'd0;
                    end
                end
                ST_RESP: begin
                    if (io.tx_ready) begin
                        if (resp_idx_q == resp_last_q)
                            resp_idx_q <= 2'd0;
                        else
                            resp_idx_q <= resp_idx_q + 2'd1;
                    end
                end
                default: begin
                    idx_q <= 2'd0;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state so they drop with the async reset.
    always_comb begin
        io.busy      = (state_q != ST_IDLE);
        io.bus_req   = (state_q == ST_REQ) || (state_q == ST_BUS);
        io.mem_valid = (state_q == ST_BUS);
        io.mem_addr  = {addr_q, 2'b00};
        io.mem_wdata = wdata_q;
        io.mem_wstrb = ((state_q == ST_BUS) && is_write_q) ? 4'hF : 4'h0;
        io.tx_valid  = (state_q == ST_RESP);
        io.tx_data   = (state_q == ST_RESP) ? byte_sel(resp_q, resp_idx_q) : 8'h00;
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: transaction-level model of expected bus accesses and
// reply bytes, a per-cycle compare process, and literal expectations on captured results.
module tb_uart_bus_master;

    localparam int BYTE_TO = 40;
    localparam int BUS_TO  = 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_bus_master_if io();

    uart_bus_master #(
        .BYTE_TIMEOUT(32'(BYTE_TO)),
        .BUS_TIMEOUT (16'(BUS_TO))
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          chk_wdata;
        int          len;
    } txn_t;

    txn_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] tx_log[$];
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    int req_cycles = 0;

    int gnt_delay = 1;
    int ready_delay = 1;
    bit never_ready = 0;
    bit spur_ready = 0;
    bit tx_rand = 0;
    logic [31:0] rdata_cfg = '0;

    // Model: what a command must produce on the bus and on tx.
    task automatic model_ping();
        exp_tx.push_back(8'h06);
    endtask

    task automatic model_read(input logic [31:0] a, input logic [31:0] d, input bit completes);
        txn_t t;
        t.addr = {a[31:2], 2'b00};
        t.wdata = '0;
        t.wstrb = 4'h0;
        t.chk_wdata = 1'b0;
        t.len = completes ? 0 : BUS_TO;
        exp_bus.push_back(t);
        if (completes) begin
            for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
        end else begin
            exp_tx.push_back(8'h15);
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int len);
        txn_t t;
        t.addr = {a[31:2], 2'b00};
        t.wdata = d;
        t.wstrb = 4'hF;
        t.chk_wdata = 1'b1;
        t.len = len;
        exp_bus.push_back(t);
        exp_tx.push_back(8'h06);
    endtask

    // Arbiter, memory responder and transmitter sink.
    initial begin
        int rq;
        int vc;
        rq = 0;
        vc = 0;
        io.bus_gnt = 1'b0;
        io.mem_ready = 1'b0;
        io.mem_rdata = '0;
        io.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst || !io.bus_req) begin
                rq = 0;
                io.bus_gnt = 1'b0;
            end else begin
                rq++;
                io.bus_gnt = (rq >= gnt_delay);
            end
            if (rst) begin
                vc = 0;
                io.mem_ready = 1'b0;
            end else if (!io.mem_valid) begin
                vc = 0;
                io.mem_ready = spur_ready && io.bus_req;
            end else if (io.mem_ready) begin
                vc = 0;
                io.mem_ready = 1'b0;
            end else begin
                vc++;
                io.mem_ready = !never_ready && (vc >= ready_delay);
            end
            io.mem_rdata = rdata_cfg;
            io.tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process.
    int cyc = 0;
    bit prev_mv = 0;
    int mv_len = 0;
    int ready_cyc = 0;
    bit ready_pend = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_mv = 0;
            mv_len = 0;
            ready_pend = 0;
        end else begin
            if (io.bus_req) req_cycles++;
            if (io.mem_valid) begin
                chk("bus_req_with_valid", io.bus_req, 1);
                mv_len++;
                if (exp_bus.size() == 0) begin
                    chk("unexpected_mem_valid", io.mem_valid, 0);
                end else begin
                    chk("mem_addr", io.mem_addr, exp_bus[0].addr);
                    chk("mem_wstrb", io.mem_wstrb, exp_bus[0].wstrb);
                    if (exp_bus[0].chk_wdata) chk("mem_wdata", io.mem_wdata, exp_bus[0].wdata);
                end
                last_addr = io.mem_addr;
                last_wdata = io.mem_wdata;
                last_wstrb = io.mem_wstrb;
                if (io.mem_ready) begin
                    ready_cyc = cyc;
                    ready_pend = 1;
                end
            end else if (prev_mv) begin
                if (exp_bus.size() > 0) begin
                    if (exp_bus[0].len != 0) chk("mem_valid_len", mv_len, exp_bus[0].len);
                    void'(exp_bus.pop_front());
                end
                mv_len = 0;
            end
            prev_mv = io.mem_valid;
            if (io.tx_valid) begin
                if (ready_pend) begin
                    chk("ready_to_tx_latency", 32'(cyc - ready_cyc <= 2), 1);
                    ready_pend = 0;
                end
                if (exp_tx.size() == 0) begin
                    chk("unexpected_tx_valid", io.tx_valid, 0);
                end else begin
                    chk("tx_data", io.tx_data, exp_tx[0]);
                    if (io.tx_ready) begin
                        tx_log.push_back(io.tx_data);
                        void'(exp_tx.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit gap);
        io.rx_data = b;
        io.rx_valid = 1'b1;
        @(posedge clk); #1;
        io.rx_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit done;
        done = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (!io.busy && exp_tx.size() == 0 && exp_bus.size() == 0) begin
                done = 1;
                break;
            end
        end
        chk({name, "_done"}, done, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tx_valid"}, io.tx_valid, 0);
        chk({tag, "_tx_data"}, io.tx_data, 0);
        chk({tag, "_bus_req"}, io.bus_req, 0);
        chk({tag, "_mem_valid"}, io.mem_valid, 0);
        chk({tag, "_mem_addr"}, io.mem_addr, 0);
        chk({tag, "_mem_wdata"}, io.mem_wdata, 0);
        chk({tag, "_mem_wstrb"}, io.mem_wstrb, 0);
        chk({tag, "_busy"}, io.busy, 0);
    endtask

    function automatic logic [7:0] log_at(input int i);
        if (i < 0 || i >= tx_log.size()) return 8'hxx;
        return tx_log[i];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        io.rx_valid = 1'b0;
        io.rx_data = 8'h00;
        #2 rst = 1'b1;
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Ping
        n = tx_log.size();
        model_ping();
        send(8'h50, 1);
        wait_idle("ping", 50);
        chk("ping_no_bus_req", req_cycles, 0);
        chk("ping_tx_count", tx_log.size() - n, 1);
        chk("ping_byte", log_at(tx_log.size() - 1), 8'h06);

        // Write with delayed grant and ready; a byte sent during REQ is dropped
        gnt_delay = 3;
        ready_delay = 5;
        n = tx_log.size();
        model_write(32'h4000_0000, 32'hDEAD_BEEF, 5);
        send(8'h57, 1); send(8'h00, 1); send(8'h00, 1); send(8'h00, 1); send(8'h40, 1);
        send(8'hEF, 1); send(8'hBE, 1); send(8'hAD, 1); send(8'hDE, 0);
        chk("write_req_latency", io.bus_req, 1);
        send(8'h50, 1);
        wait_idle("write", 100);
        chk("write_addr", last_addr, 32'h4000_0000);
        chk("write_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("write_wstrb", last_wstrb, 4'hF);
        chk("write_tx_count", tx_log.size() - n, 1);
        chk("write_ack", log_at(tx_log.size() - 1), 8'h06);

        // Read with tx backpressure and a stray mem_ready while not yet on the bus
        gnt_delay = 1;
        ready_delay = 1;
        tx_rand = 1;
        spur_ready = 1;
        rdata_cfg = 32'h1234_5678;
        n = tx_log.size();
        model_read(32'h2010_002B, 32'h1234_5678, 1);
        send(8'h52, 1); send(8'h2B, 1); send(8'h00, 1); send(8'h10, 1); send(8'h20, 0);
        chk("read_req_latency", io.bus_req, 1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (io.tx_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("read_tx_seen", seen, 1);
        send(8'h50, 1);
        wait_idle("read", 200);
        tx_rand = 0;
        spur_ready = 0;
        chk("read_tx_count", tx_log.size() - n, 4);
        chk("read_b0", log_at(n), 8'h78);
        chk("read_b1", log_at(n + 1), 8'h56);
        chk("read_b2", log_at(n + 2), 8'h34);
        chk("read_b3", log_at(n + 3), 8'h12);
        chk("read_addr", last_addr, 32'h2010_0028);
        chk("read_wstrb", last_wstrb, 4'h0);

        // Partial command dropped after inter-byte silence
        n = tx_log.size();
        send(8'h52, 1); send(8'h11, 1); send(8'h22, 0);
        repeat (BYTE_TO - 2) @(posedge clk);
        #1 chk("byte_to_still_busy", io.busy, 1);
        repeat (4) @(posedge clk);
        #1 chk("byte_to_idle", io.busy, 0);
        chk("byte_to_no_tx", tx_log.size() - n, 0);
        model_ping();
        send(8'h50, 1);
        wait_idle("ping_after_to", 50);
        chk("ping_after_to_byte", log_at(tx_log.size() - 1), 8'h06);

        // Bus timeout: responder never answers
        never_ready = 1;
        model_read(32'h8000_0000, 32'h0, 0);
        send(8'h52, 1); send(8'h00, 1); send(8'h00, 1); send(8'h00, 1); send(8'h80, 0);
        wait_idle("bus_to", BUS_TO + 60);
        chk("bus_to_nak", log_at(tx_log.size() - 1), 8'h15);

        // Reset while the bus access is outstanding
        model_read(32'h0000_0004, 32'h0, 0);
        send(8'h52, 1); send(8'h04, 1); send(8'h00, 1); send(8'h00, 1); send(8'h00, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (io.mem_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst_bus_reached", seen, 1);
        rst = 1'b1;
        #1 check_zero("rst_bus");
        exp_bus.delete();
        exp_tx.delete();
        never_ready = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Unknown command byte
        n = tx_log.size();
        exp_tx.push_back(8'h15);
        send(8'h41, 1);
        wait_idle("unknown", 50);
        chk("unknown_tx_count", tx_log.size() - n, 1);
        chk("unknown_nak", log_at(tx_log.size() - 1), 8'h15);

        repeat (5) @(posedge clk);
        #1;
        chk("exp_tx_drained", exp_tx.size(), 0);
        chk("exp_bus_drained", exp_bus.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
